// File: rtl/vending_machine_18ec068_no_change.sv
// Vending machine, price 15, coins 5 and 10, no change returned.
// Credit is held as one of S0/S5/S10. Any coin that brings the total to
// 15 or more vends and returns to S0; the excess is forfeited.
// Ports:
//   clk        - system clock, rising edge active
//   rst        - asynchronous active-low reset
//   in_5       - 5-unit coin, counted once per rising edge while high
//   in_10      - 10-unit coin, counted once per rising edge while high
//   out_bottle - registered one-cycle dispense pulse
module vending_machine_18ec068_no_change (
    input  logic clk,
    input  logic rst,
    input  logic in_5,
    input  logic in_10,
    output logic out_bottle
);

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   vend_c;

    // State and dispense registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S0;
            out_bottle <= 1'b0;
        end else begin
            state      <= next_state;
            out_bottle <= vend_c;
        end
    end

    // Next credit and vend decision from current credit plus sampled coins
    always_comb begin
        next_state = S0;
        vend_c     = 1'b0;
        case (state)
            S0: begin
                case ({in_10, in_5})
                    2'b00:   next_state = S0;
                    2'b01:   next_state = S5;
                    2'b10:   next_state = S10;
                    default: vend_c     = 1'b1;
                endcase
            end
            S5: begin
                case ({in_10, in_5})
                    2'b00:   next_state = S5;
                    2'b01:   next_state = S10;
                    default: vend_c     = 1'b1;
                endcase
            end
            S10: begin
                if (!in_5 && !in_10) begin
                    next_state = S10;
                end else begin
                    vend_c = 1'b1;
                end
            end
            // Unused encoding falls back to S0 without vending
            default: begin
                next_state = S0;
                vend_c     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vending_machine_18ec068_no_change.sv
// Self-checking bench for vending_machine_18ec068_no_change.
// A credit model predicts out_bottle for every clock edge; predictions are
// queued when coins are driven and compared after the edge.
module tb_vending_machine_18ec068_no_change;

    logic clk;
    logic rst;
    logic in_5;
    logic in_10;
    logic out_bottle;

    int   n_tests;
    int   n_fail;
    int   credit;
    logic exp_q[$];

    vending_machine_18ec068_no_change dut (
        .clk        (clk),
        .rst        (rst),
        .in_5       (in_5),
        .in_10      (in_10),
        .out_bottle (out_bottle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Drive one edge worth of coins, predict, then compare after the edge
    task automatic step(input logic c5, input logic c10, input string tag);
        int total;
        logic exp;
        @(negedge clk);
        in_5  = c5;
        in_10 = c10;
        total = credit + (c5 ? 5 : 0) + (c10 ? 10 : 0);
        if (total >= 15) begin
            exp    = 1'b1;
            credit = 0;
        end else begin
            exp    = 1'b0;
            credit = total;
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1'b1, 1'b0);
        end else begin
            check(tag, out_bottle, exp_q.pop_front());
        end
    endtask

    // Assert reset between edges and confirm immediate effect
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check(tag, out_bottle, 1'b0);
        credit = 0;
        // Coins while reset is low must be ignored
        in_5  = 1'b1;
        in_10 = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_held"}, out_bottle, 1'b0);
        @(negedge clk);
        in_5  = 1'b0;
        in_10 = 1'b0;
        rst   = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        credit  = 0;
        rst     = 1'b0;
        in_5    = 1'b0;
        in_10   = 1'b0;
        #1;
        check("reset_async", out_bottle, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", out_bottle, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Three 5-coins: S5, S10, vend
        step(1'b1, 1'b0, "five_1");
        step(1'b1, 1'b0, "five_2");
        step(1'b1, 1'b0, "five_3_vend");
        step(1'b0, 1'b0, "five_after");

        // 5 then 10, 10 then 5
        step(1'b1, 1'b0, "f_t_a");
        step(1'b0, 1'b1, "f_t_vend");
        step(1'b0, 1'b1, "t_f_a");
        step(1'b1, 1'b0, "t_f_vend");
        step(1'b0, 1'b0, "t_f_idle");

        // Two 10s: vend, excess forfeited, then 5 gives S5 only
        step(1'b0, 1'b1, "tt_a");
        step(1'b0, 1'b1, "tt_vend");
        step(1'b1, 1'b0, "tt_no_change");
        step(1'b0, 1'b1, "tt_s5_plus_10");

        // Both coins at once from S0
        step(1'b1, 1'b1, "both_vend");
        step(1'b1, 1'b0, "both_then_5");
        step(1'b0, 1'b0, "both_idle");
        step(1'b0, 1'b1, "both_then_10_vend");

        // Held in_10 for 4 edges: vends after edges 2 and 4
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $sformatf("hold10_%0d", i));

        // Back-to-back vends with both coins held
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $sformatf("b2b_%0d", i));

        // Reset during the vend pulse clears it at once
        step(1'b0, 1'b1, "rv_a");
        step(1'b0, 1'b1, "rv_vend");
        async_reset("rst_in_vend");

        // Reset from S10 discards credit
        step(1'b0, 1'b1, "r10_a");
        async_reset("rst_in_s10");
        step(1'b1, 1'b0, "r10_s5");
        step(1'b1, 1'b0, "r10_s10");
        step(1'b0, 1'b0, "r10_idle");

        // Idle 20 cycles in S10
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $sformatf("idle_%0d", i));
        step(1'b1, 1'b0, "idle_exit_vend");

        // Random coins
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $sformatf("rand_%0d", i));
        end

        if (exp_q.size() != 0) check("queue_drain", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_machine_18ec068_no_change.md
VENDING_MACHINE_18EC068_NO_CHANGE -- requirements
Module: vending_machine_18ec068_no_change

Interface
REQ-001 Parameters: none; the price is fixed at 15 units and coin values at 5 and 10.
REQ-002 clk  input  1  single system clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-004 in_5  input  1  5-unit coin indication; a high level sampled at a rising edge SHALL count as one 5-unit coin.
REQ-005 in_10  input  1  10-unit coin indication; a high level sampled at a rising edge SHALL count as one 10-unit coin.
REQ-006 out_bottle  output  1  registered dispense pulse; high for exactly one clock cycle per vend.

Function
REQ-007 The block SHALL hold accumulated credit in a state register with states S0 (0), S5 (5) and S10 (10); no other credit values SHALL be stored.
REQ-008 Coin value per edge: in_5 only = 5; in_10 only = 10; both high = 15; neither = 0.
REQ-009 At each rising edge: new_total = credit + coin value.
REQ-010 If new_total < 15: the state SHALL move to the state matching new_total, and out_bottle SHALL be 0 in the following cycle.
REQ-011 If new_total >= 15: the state SHALL return to S0, and out_bottle SHALL be 1 for the following cycle only.
REQ-012 No change is given: any excess over 15 (new_total of 20 or 25) SHALL be forfeited, and credit after a vend SHALL always be 0.
REQ-013 Latency: out_bottle SHALL rise at the same rising edge that samples the coin completing the price, and SHALL fall at the next edge unless that edge also completes a price.
REQ-014 Coins sampled during the out_bottle=1 cycle SHALL be credited normally from S0 to a new transaction, so back-to-back vends are allowed.
REQ-015 A coin input held high across N rising edges SHALL count as N coins; no edge detection is performed.
REQ-016 Transition table (state, coin -> next state, vend): S0: 0->S0; 5->S5; 10->S10; 15->S0 with vend. S5: 0->S5; 5->S10; 10->S0 with vend; 15->S0 with vend. S10: 0->S10; 5->S0 with vend; 10->S0 with vend; 15->S0 with vend.
REQ-017 An illegal or unreached state encoding SHALL recover to S0 with out_bottle=0 at the next edge.
REQ-018 Inputs with X/Z are out of scope; inputs are synchronous to clk.

Reset
REQ-019 While rst=0: state = S0 and out_bottle = 0, both asynchronously, and all coin inputs are ignored.
REQ-020 Reset asserted mid-transaction SHALL discard the accumulated credit with no vend.
REQ-021 After rst returns to 1, the first rising edge SHALL process coins from S0.

Verification
REQ-022 Release reset, apply in_5=1 for 3 consecutive edges -> states S5, S10, then S0; out_bottle=1 only in the cycle after the 3rd edge.
REQ-023 Apply in_5 for one edge, then in_10 for one edge -> vend pulse after the 2nd edge; credit 0 afterwards. Apply in_10 then in_5 -> same result.
REQ-024 Apply in_10 for 2 edges -> vend after the 2nd edge, state S0 (5 excess forfeited, no change). Then apply in_5 for one edge -> S5, with no vend.
REQ-025 From S0 apply in_5=in_10=1 for one edge -> immediate vend, S0. Hold in_10=1 for 4 edges -> 2 vend pulses, one after edge 2 and one after edge 4.
REQ-026 In S10, assert rst=0 between clock edges -> state S0 and out_bottle=0 at once. Release reset, apply in_5 for one edge -> S5, with no vend.
REQ-027 Idle inputs (both 0) for 20 cycles in any state -> state unchanged and out_bottle stays 0.
